dr_phase_tracker: RTL
=====================

// Module: dr_phase_tracker
// PURPOSE
//   Parametrised oversampled clock/data recovery for the USB2 receive path. Takes NPHASE
//   samples of the line per bit period (one per phase of the multi-phase clock, already
//   retimed into the bit clock domain), builds an edge histogram per phase, and steps
//   the sampling phase toward the eye centre. Emits one recovered bit per cycle, a lock
//   flag and slip pulses that the downstream elastic buffer consumes.
// PARAMETERS
//   NPHASE     10  samples per bit period; even, >= 4
//   WINDOW     16  edge-bearing cycles per phase decision; power of 2, >= 2
//   LOCK_COUNT  4  consecutive on-target decisions required to assert locked
// PORTS
//   clock       in   1                 bit clock (480 MHz); all logic on its rising edge
//   reset       in   1                 synchronous, active-high
//   enable      in   1                 1 = samples valid this cycle
//   track_en    in   1                 1 = phase may move; 0 = phase frozen
//   samples     in   NPHASE            samples[k] taken at k/NPHASE UI; [0] earliest
//   data_out    out  1                 recovered bit
//   out_valid   out  1                 data_out valid
//   sel_phase   out  $clog2(NPHASE)    current sampling phase
//   locked      out  1                 phase stable for LOCK_COUNT decisions
//   slip_fwd    out  1                 1-cycle pulse: sel_phase wrapped NPHASE-1 -> 0
//   slip_back   out  1                 1-cycle pulse: sel_phase wrapped 0 -> NPHASE-1
// BEHAVIOUR
// - Reset: data_out=0, out_valid=0, sel_phase=NPHASE/2, locked=0, slips=0; histogram,
//   window counter, lock counter, prev_last cleared. Reset mid-window discards partial data.
// - Output: data_out <= samples[sel_phase] (sel_phase value before the edge);
//   out_valid <= enable. Latency 1 cycle. enable=0: no counting, data_out holds.
// - Edges (only when enable=1): edge[0]=samples[0]^prev_last; edge[k]=samples[k]^samples[k-1].
//   prev_last <= samples[NPHASE-1] on every enabled cycle.
// - Histogram: cnt[k] += edge[k], saturating at WINDOW. Window counter counts enabled
//   cycles with any edge bit set (one per cycle regardless of edge count).
// - Decision cycle: window counter reaches WINDOW including current cycle; decision uses
//   histogram including current edges. All counters cleared at that edge.
// - Decision: e = argmax cnt (lowest index wins ties); target = (e+NPHASE/2) mod NPHASE.
//   target==sel_phase: lock counter +1, saturate at LOCK_COUNT.
//   else: lock counter=0, locked=0; if track_en, sel_phase moves one step along shortest
//   circular path; distance exactly NPHASE/2 steps +1. track_en=0: no move, lock still scored.
// - locked = (lock counter == LOCK_COUNT), registered, updates with decision.
// - Step NPHASE-1 -> 0 pulses slip_fwd; 0 -> NPHASE-1 pulses slip_back; same edge as
//   sel_phase update. Never both. Max one step per WINDOW edge cycles.
// - No edges (constant line): no decisions; sel_phase, locked unchanged indefinitely.
// TESTING
// - Reset held 3 cycles with random samples -> all outputs 0, sel_phase=5, locked=0.
// - Alternate 0x000/0x3FF each cycle (edge at phase 0) -> target 5, no moves; locked=1
//   after 64 cycles; data_out equals samples[5] delayed 1 cycle, out_valid follows enable.
// - Edge at phase 3 (samples[2:0] differ from [9:3]) -> sel 5->6->7->8 at cycles 16,32,48;
//   locked rises after 4 further decisions (cycle 112).
// - Edge at phase 4 until sel=9, then phase 6 -> step 9->0 with slip_fwd single pulse,
//   then 0->1; slip_back never asserted. Mirror case checks slip_back.
// - track_en=0 with edge at phase 3 -> sel_phase stays 5, locked stays 0; raise track_en
//   -> movement resumes at next decision.
// - 10 window cycles, reset, then 15 edge cycles -> no decision; 16th -> decision;
//   enable=0 gaps inside window do not advance counter or change data_out.

Source files
------------

// File: rtl/dr_phase_tracker.sv
// Oversampled clock/data recovery: per-phase edge histogram over a window of edge-bearing
// cycles, stepping the sampling phase toward the eye centre with lock and slip reporting.
module dr_phase_tracker #(
  parameter int NPHASE     = 10,
  parameter int WINDOW     = 16,
  parameter int LOCK_COUNT = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      track_en,
  input  logic [NPHASE-1:0]         samples,
  output logic                      data_out,
  output logic                      out_valid,
  output logic [$clog2(NPHASE)-1:0] sel_phase,
  output logic                      locked,
  output logic                      slip_fwd,
  output logic                      slip_back
);

  localparam int PW = $clog2(NPHASE);
  localparam int CW = $clog2(WINDOW + 1);
  localparam int LW = $clog2(LOCK_COUNT + 1);
  localparam logic [PW-1:0] SEL_RESET = PW'(NPHASE / 2);
  localparam logic [PW-1:0] SEL_LAST  = PW'(NPHASE - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(WINDOW);
  localparam logic [CW-1:0] WIN_LAST  = CW'(WINDOW - 1);
  localparam logic [LW-1:0] LOCK_MAX  = LW'(LOCK_COUNT);

  logic [NPHASE-1:0] edge_s;
  logic              any_edge_s;
  logic              decide_s;
  logic [CW-1:0]     cnt_r      [NPHASE];
  logic [CW-1:0]     cnt_next_s [NPHASE];
  logic [CW-1:0]     win_cnt_r;
  logic [LW-1:0]     lock_cnt_r;
  logic [LW-1:0]     lock_cnt_next_s;
  logic              locked_next_s;
  logic              prev_last_r;
  logic [PW-1:0]     best_idx_s;
  logic [CW-1:0]     best_cnt_s;
  logic [PW-1:0]     target_s;
  int                dist_s;
  logic [PW-1:0]     sel_next_s;
  logic              fwd_s;
  logic              back_s;

  // Edge detection and saturating histogram increment
  always_comb begin
    edge_s[0] = samples[0] ^ prev_last_r;
    for (int k = 1; k < NPHASE; k++) begin
      edge_s[k] = samples[k] ^ samples[k-1];
    end
    for (int k = 0; k < NPHASE; k++) begin
      if (edge_s[k] && (cnt_r[k] != CNT_MAX)) begin
        cnt_next_s[k] = cnt_r[k] + CW'(1);
      end else begin
        cnt_next_s[k] = cnt_r[k];
      end
    end
    any_edge_s = |edge_s;
    decide_s   = enable && any_edge_s && (win_cnt_r == WIN_LAST);
  end

  // Phase decision: argmax (lowest index on ties), target, step direction and lock scoring
  always_comb begin
    best_idx_s = '0;
    best_cnt_s = cnt_next_s[0];
    for (int k = 1; k < NPHASE; k++) begin
      best_idx_s = (cnt_next_s[k] > best_cnt_s) ? PW'(k) : best_idx_s;
      best_cnt_s = (cnt_next_s[k] > best_cnt_s) ? cnt_next_s[k] : best_cnt_s;
    end
    target_s = PW'((int'(best_idx_s) + NPHASE / 2) % NPHASE);
    dist_s   = (int'(target_s) - int'(sel_phase) + NPHASE) % NPHASE;

    sel_next_s      = sel_phase;
    fwd_s           = 1'b0;
    back_s          = 1'b0;
    lock_cnt_next_s = lock_cnt_r;
    locked_next_s   = locked;
    if (decide_s) begin
      if (dist_s == 0) begin
        lock_cnt_next_s = (lock_cnt_r == LOCK_MAX) ? lock_cnt_r : lock_cnt_r + LW'(1);
      end else begin
        lock_cnt_next_s = '0;
        if (!track_en) begin
          sel_next_s = sel_phase;
        end else if (dist_s <= NPHASE / 2) begin
          // Half-way ambiguity resolves forward
          fwd_s      = (sel_phase == SEL_LAST);
          sel_next_s = fwd_s ? PW'(0) : sel_phase + PW'(1);
        end else begin
          back_s     = (sel_phase == PW'(0));
          sel_next_s = back_s ? SEL_LAST : sel_phase - PW'(1);
        end
      end
      locked_next_s = (lock_cnt_next_s == LOCK_MAX);
    end else begin
      lock_cnt_next_s = lock_cnt_r;
    end
  end

  // State and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      data_out    <= 1'b0;
      out_valid   <= 1'b0;
      sel_phase   <= SEL_RESET;
      locked      <= 1'b0;
      slip_fwd    <= 1'b0;
      slip_back   <= 1'b0;
      win_cnt_r   <= '0;
      lock_cnt_r  <= '0;
      prev_last_r <= 1'b0;
      for (int k = 0; k < NPHASE; k++) begin
        cnt_r[k] <= '0;
      end
    end else begin
      out_valid  <= enable;
      slip_fwd   <= fwd_s;
      slip_back  <= back_s;
      sel_phase  <= sel_next_s;
      lock_cnt_r <= lock_cnt_next_s;
      locked     <= locked_next_s;
      if (enable) begin
        data_out    <= samples[sel_phase];
        prev_last_r <= samples[NPHASE-1];
        if (decide_s) begin
          win_cnt_r <= '0;
          for (int k = 0; k < NPHASE; k++) begin
            cnt_r[k] <= '0;
          end
        end else if (any_edge_s) begin
          win_cnt_r <= win_cnt_r + CW'(1);
          for (int k = 0; k < NPHASE; k++) begin
            cnt_r[k] <= cnt_next_s[k];
          end
        end
      end
    end
  end

endmodule
